// File: rtl/grf_wb_if.sv
// rtl/grf_wb_if.sv - writeback / register-read bundle for the grf_wb register file
//
// Purpose: groups the W-stage write controls, the D-stage read ports and the
// commit counter into one bundle.
//   master : pipeline side (drives W-stage controls and read addresses)
//   slave  : register file side (drives read data and the commit counter)
// Signals:
//   regwrite, wdctr[1:0], waddrW, aluoutW, memdataW, pcW  - W-stage write request
//   raddr1, raddr2                                         - D-stage read addresses
//   rdata1, rdata2                                         - D-stage read data
//   wr_count[31:0]                                         - committed writes since reset

interface grf_wb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          regwrite;
    logic [1:0]    wdctr;
    logic [AW-1:0] waddrW;
    logic [DW-1:0] aluoutW;
    logic [DW-1:0] memdataW;
    logic [DW-1:0] pcW;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [31:0]   wr_count;

    modport master (
        output regwrite, wdctr, waddrW, aluoutW, memdataW, pcW, raddr1, raddr2,
        input  rdata1, rdata2, wr_count
    );

    modport slave (
        input  regwrite, wdctr, waddrW, aluoutW, memdataW, pcW, raddr1, raddr2,
        output rdata1, rdata2, wr_count
    );
endinterface

// File: rtl/grf_wb.sv
// rtl/grf_wb.sv - 32x32 general register file with writeback select and write-through bypass
//
// Purpose: commits the W-stage result (ALU / load data / PC+8) into a 32-entry
// register file and serves two combinational D-stage read ports. A value being
// committed this cycle is forwarded straight to matching read ports. Register 0
// is hard-wired to zero.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears the array and wr_count
//   bus   - grf_wb_if.slave: W-stage write request, D-stage reads, wr_count
// Optional feature: define GRF_WB_TRACE_EN to print one trace line per committed
// write, in the same format as the reference simulator log.

module grf_wb #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic       clk,
    input  logic       reset,
    grf_wb_if.slave    bus
);

    logic [DW-1:0] regs_q [NREG];
    logic [31:0]   wr_count_q;
    logic [31:0]   wr_count_d;

    logic [DW-1:0] pc_plus8;
    logic [DW-1:0] wsel;
    logic          we_eff;

    assign pc_plus8 = bus.pcW + DW'(8);

    always_comb begin
        wsel = '0;
        unique case (bus.wdctr)
            2'b00:   wsel = bus.aluoutW;
            2'b01:   wsel = bus.memdataW;
            2'b10:   wsel = pc_plus8;
            default: wsel = '0;
        endcase
    end

    // Writes to $0 and the reserved select are dropped entirely: no commit,
    // no count, no bypass. Reset also masks the write so it cannot leak through.
    assign we_eff = bus.regwrite && (bus.waddrW != AW'(0)) && (bus.wdctr != 2'b11) && !reset;

    assign wr_count_d = we_eff ? wr_count_q + 32'd1 : wr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (we_eff) begin
                regs_q[bus.waddrW] <= wsel;
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Write-through: the D stage sees the value being committed this cycle.
    always_comb begin
        bus.rdata1 = '0;
        if (!reset && bus.raddr1 != AW'(0)) begin
            bus.rdata1 = (we_eff && bus.raddr1 == bus.waddrW) ? wsel : regs_q[bus.raddr1];
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (!reset && bus.raddr2 != AW'(0)) begin
            bus.rdata2 = (we_eff && bus.raddr2 == bus.waddrW) ? wsel : regs_q[bus.raddr2];
        end
    end

    assign bus.wr_count = wr_count_q;

`ifdef GRF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (we_eff) begin
            $display("@%h: $%d <= %h", bus.pcW, bus.waddrW, wsel);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_wb.sv
// tb/tb_grf_wb.sv - self-checking bench for grf_wb against a behavioural register-file model

module tb_grf_wb;

    logic clk;
    logic reset;

    grf_wb_if #(.AW(5), .DW(32)) bif ();

    grf_wb #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain array plus commit counter.
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    int compared;
    int mismatched;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sel_value(input logic [1:0] ctr, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [31:0] pc);
        case (ctr)
            2'd0:    return alu;
            2'd1:    return mem;
            2'd2:    return pc + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic rst, input logic commits,
                                               input logic [4:0] wa, input logic [31:0] val);
        if (rst || ra == 5'd0) return 32'd0;
        if (commits && ra == wa) return val;
        return model_regs[ra];
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then let
    // the edge commit and update the model to match the architectural rules.
    task automatic step(input string tag, input logic rst, input logic rw, input logic [1:0] ctr,
                        input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2);
        logic [31:0] val;
        logic        commits;
        @(negedge clk);
        reset        = rst;
        bif.regwrite = rw;
        bif.wdctr    = ctr;
        bif.waddrW   = wa;
        bif.aluoutW  = alu;
        bif.memdataW = mem;
        bif.pcW      = pc;
        bif.raddr1   = ra1;
        bif.raddr2   = ra2;
        #1;
        val     = sel_value(ctr, alu, mem, pc);
        commits = rw && !rst && wa != 5'd0 && ctr != 2'd3;
        check({tag, ".rdata1"}, bif.rdata1, model_read(ra1, rst, commits, wa, val));
        check({tag, ".rdata2"}, bif.rdata2, model_read(ra2, rst, commits, wa, val));
        check({tag, ".wr_count"}, bif.wr_count, model_count);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_count = 32'd0;
        end else if (commits) begin
            model_regs[wa] = val;
            model_count    = model_count + 32'd1;
        end
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        compared   = 0;
        mismatched = 0;

        reset        = 1'b1;
        bif.regwrite = 1'b0;
        bif.wdctr    = 2'd0;
        bif.waddrW   = 5'd0;
        bif.aluoutW  = 32'd0;
        bif.memdataW = 32'd0;
        bif.pcW      = 32'd0;
        bif.raddr1   = 5'd0;
        bif.raddr2   = 5'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;

        // Reset state on every address
        for (int a = 0; a < 32; a++) begin
            step("rst_read", 1'b0, 1'b0, 2'd0, 5'd0, 0, 0, 0, 5'(a), 5'(31 - a));
        end

        // ALU write with bypass, then array readback
        step("alu_byp", 1'b0, 1'b1, 2'd0, 5'd8, 32'h1234, 32'h0, 32'h0, 5'd8, 5'd1);
        step("alu_arr", 1'b0, 1'b0, 2'd0, 5'd8, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8);
        check("alu_arr.count_is_1", bif.wr_count, 32'd1);

        // PC+8 select, both ports on the written register
        step("pc8_byp", 1'b0, 1'b1, 2'd2, 5'd31, 32'h0, 32'h0, 32'h3000, 5'd31, 5'd31);
        step("pc8_arr", 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd31);
        check("pc8_arr.value", bif.rdata1, 32'h3008);

        // Write to $0 is suppressed, no bypass
        step("r0_write", 1'b0, 1'b1, 2'd1, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd8, 5'd0);
        step("r0_after", 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);

        // Reserved select is suppressed
        step("r5_set", 1'b0, 1'b1, 2'd0, 5'd5, 32'h77, 32'h0, 32'h0, 5'd5, 5'd0);
        step("rsv_sel", 1'b0, 1'b1, 2'd3, 5'd5, 32'h99, 32'h99, 32'h99, 5'd5, 5'd5);
        step("rsv_after", 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
        check("rsv_after.r5", bif.rdata2, 32'h77);

        // Reset dominates a concurrent write; first write after reset is accepted
        step("r3_pre", 1'b0, 1'b1, 2'd0, 5'd3, 32'h11, 32'h0, 32'h0, 5'd3, 5'd8);
        step("rst_wr", 1'b1, 1'b1, 2'd0, 5'd3, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3);
        step("post_rst", 1'b0, 1'b1, 2'd1, 5'd4, 32'h0, 32'hCAFE, 32'h0, 5'd3, 5'd4);
        step("post_rst2", 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd8);
        check("post_rst2.count", bif.wr_count, 32'd1);

        // Randomised traffic with biased address collisions
        for (int n = 0; n < 400; n++) begin
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 31));
            step("rand", ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), wa, $urandom, $urandom, $urandom, ra1, ra2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
